ht_cmd_arbiter: RTL and testbench



---
 rtl/ht_cmd_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_ht_cmd_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ht_cmd_arbiter.sv
// ht_cmd_arbiter: shares one hash-table command/result port pair between
// REQ_CNT requesters. Commands are granted round-robin into one registered
// output stage. The issuer ID of every command goes into an in-order tag FIFO,
// which steers each returning result back to its issuer. OP_INIT is handled
// as a drain barrier: it is issued only with nothing in flight, and nothing
// else is issued until its own result has come back.

package ht_cmd_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_INIT   = 2'd3
  } ht_opcode_t;

  typedef struct packed {
    ht_opcode_t  opcode;
    logic [15:0] key;
    logic [15:0] value;
  } ht_command_t;

  typedef struct packed {
    logic        found;
    logic [15:0] value;
  } ht_result_t;

endpackage

module ht_cmd_arbiter
  import ht_cmd_arbiter_pkg::*;
#(
  parameter int REQ_CNT         = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int ID_W            = $clog2(REQ_CNT),
  localparam int CMD_W          = $bits(ht_command_t),
  localparam int RES_W          = $bits(ht_result_t),
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  // requester command side
  input  logic [REQ_CNT-1:0][CMD_W-1:0]   req_cmd_i,
  input  logic [REQ_CNT-1:0]              req_valid_i,
  output logic [REQ_CNT-1:0]              req_ready_o,
  // hash table command side
  output logic [CMD_W-1:0]                ht_cmd_o,
  output logic                            ht_cmd_valid_o,
  input  logic                            ht_cmd_ready_i,
  // hash table result side
  input  logic [RES_W-1:0]                ht_res_i,
  input  logic                            ht_res_valid_i,
  output logic                            ht_res_ready_o,
  // requester result side
  output logic [RES_W-1:0]                res_o,
  output logic [REQ_CNT-1:0]              res_valid_o,
  input  logic [REQ_CNT-1:0]              res_ready_i,
  // status
  output logic [CNT_W-1:0]                outstanding_o,
  output logic                            init_busy_o,
  output logic                            err_unexp_res_o
);

  localparam int                PTR_W    = $clog2(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(REQ_CNT - 1);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_INIT_DRAIN = 2'd1,
    ST_INIT_WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_q;
  logic [ID_W-1:0]   init_id_q, init_id_d;

  // output stage
  logic [CMD_W-1:0]  cmd_q;
  logic              cmd_vld_q;
  logic              stage_free;

  // tag FIFO
  logic [ID_W-1:0]   tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              fifo_empty, can_issue;
  logic [ID_W-1:0]   head_id;

  // arbitration
  logic              win_vld;
  logic [ID_W-1:0]   win_id;
  ht_command_t       win_cmd;
  logic              grant;
  logic [ID_W-1:0]   grant_id;

  logic              push, pop, unexp;
  logic              err_q;

  // Requester IDs wrap at REQ_CNT, which need not be a power of two.
  function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + ID_W'(1);
  endfunction

  assign stage_free = !cmd_vld_q || ht_cmd_ready_i;
  assign fifo_empty = (cnt_q == '0);
  // Registered count only: a pop this cycle does not open a slot until next cycle.
  assign can_issue  = stage_free && (cnt_q < FULL_CNT);
  assign head_id    = tag_mem[rd_ptr_q];

  // Round-robin search: first valid requester at or after the RR pointer.
  always_comb begin
    logic [ID_W-1:0] idx;
    win_vld = 1'b0;
    win_id  = rr_q;
    idx     = rr_q;
    for (int i = 0; i < REQ_CNT; i++) begin
      if (!win_vld && req_valid_i[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
      idx = inc_id(idx);
    end
  end

  assign win_cmd = req_cmd_i[win_id];

  // FSM next state and grant decision; INIT is parked until the pipe is empty.
  always_comb begin
    state_d   = state_q;
    init_id_d = init_id_q;
    grant     = 1'b0;
    grant_id  = win_id;
    unique case (state_q)
      ST_RUN: begin
        if (win_vld) begin
          if (win_cmd.opcode == OP_INIT) begin
            state_d   = ST_INIT_DRAIN;
            init_id_d = win_id;
          end else if (can_issue) begin
            grant = 1'b1;
          end
        end
      end
      ST_INIT_DRAIN: begin
        grant_id = init_id_q;
        if (fifo_empty && stage_free && req_valid_i[init_id_q]) begin
          grant   = 1'b1;
          state_d = ST_INIT_WAIT;
        end
      end
      ST_INIT_WAIT: begin
        // only the INIT tag is in the FIFO here, so any pop is its result
        if (pop) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (rst_i) grant = 1'b0;
  end

  // One-hot ready to the granted requester.
  always_comb begin
    req_ready_o           = '0;
    req_ready_o[grant_id] = grant;
  end

  // Result steering by the tag at the FIFO head; unmatched results are dropped.
  always_comb begin
    res_valid_o = '0;
    if (!fifo_empty && !rst_i) res_valid_o[head_id] = ht_res_valid_i;
    ht_res_ready_o = fifo_empty ? 1'b1 : res_ready_i[head_id];
  end

  assign res_o = ht_res_i;
  assign push  = grant;
  assign pop   = ht_res_valid_i && !fifo_empty && res_ready_i[head_id] && !rst_i;
  assign unexp = ht_res_valid_i && fifo_empty;

  // Control state: FSM, RR pointer, output stage, FIFO pointers/count, error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      rr_q      <= '0;
      init_id_q <= '0;
      cmd_q     <= '0;
      cmd_vld_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_id_q <= init_id_d;
      if (stage_free) begin
        cmd_vld_q <= grant;
        if (grant) cmd_q <= req_cmd_i[grant_id];
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        rr_q     <= inc_id(grant_id);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (unexp) err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset; entries are only read behind the count.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wr_ptr_q] <= grant_id;
  end

  assign ht_cmd_o        = cmd_q;
  assign ht_cmd_valid_o  = cmd_vld_q;
  assign outstanding_o   = cnt_q;
  assign init_busy_o     = (state_q != ST_RUN);
  assign err_unexp_res_o = err_q;

  a_grant_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(req_ready_o));
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    cnt_q <= FULL_CNT);
  a_cmd_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (ht_cmd_valid_o && !ht_cmd_ready_i) |=> (ht_cmd_valid_o && $stable(ht_cmd_o)));

endmodule

// File: tb/tb_ht_cmd_arbiter.sv
// Bench for ht_cmd_arbiter. Requesters and a hash-table model are driven from
// one process; expected grant order and commands are queued by the directed
// phases, and negedge monitors pop and compare. Each command's key carries
// its issuer in key[15:12] and the table model returns value=key, so routing
// is checked against the bench's own encoding.

module tb_ht_cmd_arbiter;
  import ht_cmd_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int MAXO = 16;
  localparam int CW   = $bits(ht_command_t);
  localparam int OW   = $clog2(MAXO) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0][CW-1:0] req_cmd;
  logic [N-1:0]         req_valid, req_ready;
  ht_command_t          ht_cmd;
  logic                 ht_cmd_valid, ht_cmd_ready;
  ht_result_t           ht_res, res;
  logic                 ht_res_valid, ht_res_ready;
  logic [N-1:0]         res_valid, res_ready;
  logic [OW-1:0]        outstanding;
  logic                 init_busy, err;

  always #5 clk = ~clk;

  ht_cmd_arbiter #(.REQ_CNT(N), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_cmd_i(req_cmd), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .ht_cmd_o(ht_cmd), .ht_cmd_valid_o(ht_cmd_valid), .ht_cmd_ready_i(ht_cmd_ready),
    .ht_res_i(ht_res), .ht_res_valid_i(ht_res_valid), .ht_res_ready_o(ht_res_ready),
    .res_o(res), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .outstanding_o(outstanding), .init_busy_o(init_busy), .err_unexp_res_o(err)
  );

  int checks = 0, errors = 0;
  int budget[N], seq[N], seq_pred[N], delivered[N];
  ht_opcode_t req_op[N];
  int  res_credit;
  bit  force_res, unexp_mode;
  ht_result_t  pend[$];
  int          exp_grant[$];
  ht_command_t exp_cmd[$];

  function automatic ht_command_t make_cmd(int r, int s, ht_opcode_t op);
    ht_command_t c;
    c.opcode = op;
    c.key    = {r[3:0], s[11:0]};
    c.value  = 16'h5A00 ^ s[15:0];
    return c;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(string name, int n, int lim);
    checks++;
    if (n >= lim) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles", name, n);
    end
  endtask

  task automatic expect_grant(int r, ht_opcode_t op);
    exp_grant.push_back(r);
    exp_cmd.push_back(make_cmd(r, seq_pred[r], op));
    seq_pred[r]++;
  endtask

  // Wait for all queued grants to happen and the count to settle at target.
  task automatic settle(int target, string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_grant.size() == 0 && int'(outstanding) == target && !ht_cmd_valid) && n < 400);
    timeout(name, n, 400);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_cmd_valid"}, ht_cmd_valid, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_outstanding"}, outstanding, 0);
    chk({tag, "_init_busy"}, init_busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Requester and hash-table model: sample handshakes at negedge, update at posedge+2.
  logic [N-1:0] acc_req;
  logic         acc_cmd, acc_res;
  ht_command_t  cap;
  initial begin
    req_valid = '0; req_cmd = '0; ht_res_valid = 1'b0; ht_res = '0;
    forever begin
      @(negedge clk);
      acc_req = req_ready;
      acc_cmd = ht_cmd_valid && ht_cmd_ready;
      cap     = ht_cmd;
      acc_res = ht_res_valid && ht_res_ready && !force_res;
      @(posedge clk);
      #2;
      for (int r = 0; r < N; r++)
        if (acc_req[r]) begin seq[r]++; budget[r]--; end
      if (acc_res) begin
        if (pend.size() > 0) void'(pend.pop_front());
        if (res_credit > 0) res_credit--;
      end
      if (acc_cmd) begin
        ht_result_t rr;
        rr.found = 1'b1;
        rr.value = cap.key;
        pend.push_back(rr);
      end
      for (int r = 0; r < N; r++) begin
        req_valid[r] = budget[r] > 0;
        req_cmd[r]   = make_cmd(r, seq[r], req_op[r]);
      end
      ht_res_valid = force_res || (res_credit > 0 && pend.size() > 0);
      ht_res = force_res ? ht_result_t'({1'b0, 16'hDEAD}) : (pend.size() > 0 ? pend[0] : '0);
    end
  end

  // Scoreboard monitors.
  always @(negedge clk) begin
    int id;
    if (!rst) begin
      chk("outstanding_bound", outstanding > OW'(MAXO), 0);
      if (|req_ready) begin
        if (exp_grant.size() == 0) chk("grant_unexpected", req_ready, 0);
        else chk("grant_order", req_ready, 64'd1 << exp_grant.pop_front());
      end
      if (ht_cmd_valid && ht_cmd_ready) begin
        if (exp_cmd.size() == 0) chk("cmd_unexpected", ht_cmd, 0);
        else chk("ht_cmd", ht_cmd, exp_cmd.pop_front());
      end
      if (ht_res_valid && !force_res && !unexp_mode) begin
        id = int'(ht_res.value[15:12]);
        chk("res_route", res_valid, 64'd1 << id);
        chk("res_ready", ht_res_ready, res_ready[id]);
        chk("res_data", res, ht_res);
        if (ht_res_ready) delivered[id]++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  ht_command_t held_exp;
  ht_result_t  exp_r;
  int          d1;
  int          n;

  initial begin
    rst = 1'b1; ht_cmd_ready = 1'b1; res_ready = '1;
    res_credit = 0; force_res = 0; unexp_mode = 0;
    for (int r = 0; r < N; r++) begin
      budget[r] = 0; seq[r] = 0; seq_pred[r] = 0; delivered[r] = 0; req_op[r] = OP_SEARCH;
    end
    @(posedge clk); @(negedge clk);
    check_reset_outputs("in_rst");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Phase 1: all four requesters busy, round-robin 0,1,2,3,...
    @(posedge clk); #1;
    res_credit = 1000;
    for (int k = 0; k < 3; k++) for (int r = 0; r < N; r++) expect_grant(r, OP_SEARCH);
    for (int r = 0; r < N; r++) budget[r] = 3;
    settle(0, "p1_drain");
    for (int r = 0; r < N; r++) chk("p1_delivered", delivered[r], 3);

    // Phase 2: hash table stalls with a command in the stage.
    @(posedge clk); #1;
    ht_cmd_ready = 1'b0;
    held_exp = make_cmd(0, seq_pred[0], OP_SEARCH);
    for (int k = 0; k < 2; k++) for (int r = 0; r < N; r++) expect_grant(r, OP_SEARCH);
    for (int r = 0; r < N; r++) budget[r] = 2;
    @(negedge clk);
    chk("stall_first_grant", req_ready, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", ht_cmd_valid, 1);
      chk("stall_cmd", ht_cmd, held_exp);
      chk("stall_no_grant", req_ready, 0);
    end
    @(posedge clk); #1 ht_cmd_ready = 1'b1;
    settle(0, "p2_drain");

    // Phase 3: no results until 16 outstanding.
    @(posedge clk); #1;
    res_credit = 0;
    for (int k = 0; k < 5; k++) for (int r = 0; r < N; r++) expect_grant(r, OP_SEARCH);
    for (int r = 0; r < N; r++) budget[r] = 5;
    n = 0;
    do begin @(negedge clk); n++; end while (int'(outstanding) != MAXO && n < 60);
    timeout("p3_fill", n, 60);
    for (int k = 0; k < 3; k++) begin
      chk("full_no_grant", req_ready, 0);
      chk("full_cnt", outstanding, MAXO);
      @(negedge clk);
    end
    @(posedge clk); #1 res_credit = 1;
    @(negedge clk);
    chk("full_pop_no_grant", req_ready, 0);
    chk("full_pop_hs", ht_res_valid && ht_res_ready, 1);
    @(negedge clk);
    chk("after_pop_cnt", outstanding, MAXO - 1);
    chk("after_pop_grant", req_ready, 4'b0001);
    @(posedge clk); #1 res_credit = 1000;
    settle(0, "p3_drain");

    // Phase 4: INIT from requester 2 with 3 outstanding.
    @(posedge clk); #1;
    res_credit = 0;
    for (int k = 0; k < 3; k++) expect_grant(1, OP_SEARCH);
    budget[1] = 3;
    settle(3, "p4_setup");
    @(posedge clk); #1;
    req_op[2] = OP_INIT;
    expect_grant(2, OP_INIT);
    expect_grant(3, OP_SEARCH);
    expect_grant(1, OP_SEARCH);
    budget[1] = 1; budget[2] = 1; budget[3] = 1;
    @(negedge clk);
    chk("init_seen_no_grant", req_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("drain_busy", init_busy, 1);
      chk("drain_no_grant", req_ready, 0);
      chk("drain_cnt", outstanding, 3);
    end
    @(posedge clk); #1 res_credit = 3;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[2] && n < 40);
    timeout("init_grant_wait", n, 40);
    chk("init_grant_cnt", outstanding, 0);
    chk("init_grant_busy", init_busy, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("wait_no_grant", req_ready, 0);
      chk("wait_busy", init_busy, 1);
      chk("wait_cnt", outstanding, 1);
    end
    @(posedge clk); #1 res_credit = 1000;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready == '0 && n < 40);
    timeout("post_init_wait", n, 40);
    chk("post_init_grant", req_ready, 4'b1000);
    chk("post_init_busy", init_busy, 0);
    settle(0, "p4_drain");
    req_op[2] = OP_SEARCH;

    // Phase 5: requester 1 not ready for its result for 4 cycles.
    @(posedge clk); #1;
    res_credit = 0;
    exp_r.found = 1'b1;
    exp_r.value = make_cmd(1, seq_pred[1], OP_SEARCH).key;
    expect_grant(1, OP_SEARCH);
    budget[1] = 1;
    settle(1, "p5_setup");
    d1 = delivered[1];
    @(posedge clk); #1;
    res_ready = 4'b1101;
    res_credit = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_res_valid", res_valid, 4'b0010);
      chk("hold_ht_ready", ht_res_ready, 0);
      chk("hold_res", res, exp_r);
    end
    @(posedge clk); #1 res_ready = '1;
    settle(0, "p5_drain");
    chk("p5_delivered", delivered[1], d1 + 1);

    // Phase 6: result with an empty FIFO.
    @(posedge clk); #1 force_res = 1;
    @(negedge clk);
    chk("unexp_ready", ht_res_ready, 1);
    chk("unexp_res_valid", res_valid, 0);
    chk("unexp_err_before", err, 0);
    @(posedge clk); #1 force_res = 0;
    @(negedge clk);
    chk("unexp_err_set", err, 1);
    repeat (3) @(negedge clk);
    chk("unexp_err_sticky", err, 1);

    // Phase 7: reset with two commands in flight; their results are then unexpected.
    @(posedge clk); #1;
    res_credit = 0;
    expect_grant(0, OP_SEARCH);
    expect_grant(0, OP_SEARCH);
    budget[0] = 2;
    settle(2, "p7_setup");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    unexp_mode = 1;
    res_credit = 2;
    @(negedge clk);
    chk("stale_ready", ht_res_ready, 1);
    chk("stale_res_valid", res_valid, 0);
    @(negedge clk);
    chk("stale_err", err, 1);
    chk("stale_cnt", outstanding, 0);

    chk("grant_q_empty", exp_grant.size(), 0);
    chk("cmd_q_empty", exp_cmd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
